// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction-fetch sequencer for the RV32 core. Owns the program counter,
// runs the imem request/acknowledge handshake, buffers one instruction for
// decode with backpressure, and applies branch/jalr redirects from execute.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 synchronous reset, active-low
//   imem_req/imem_addr  fetch request and word-aligned address (decoded from state/pc)
//   imem_ack/imem_rdata memory accept strobe, instruction valid in the same cycle
//   br_taken/br_target  taken branch/jal redirect (wins over jalr)
//   jr_valid/jr_target  jalr redirect
//   if_valid/if_instr/if_pc  buffered instruction handed to decode
//   id_ready            decode accepts the buffered instruction
//   pc                  current fetch PC
//   pc_src              source of last PC update: 00 pc+4, 01 branch, 10 jalr
//   fetch_cnt           instructions handed to decode (wraps)
module fetch_sequencer #(
  parameter int unsigned     DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  br_taken,
  input  logic [DATA_WIDTH-1:0] br_target,
  input  logic                  jr_valid,
  input  logic [DATA_WIDTH-1:0] jr_target,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [DATA_WIDTH-1:0] if_pc,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [1:0]            pc_src,
  output logic [31:0]           fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP,
    S_HOLD
  } state_t;

  localparam logic [1:0] SRC_SEQ = 2'b00;
  localparam logic [1:0] SRC_BR  = 2'b01;
  localparam logic [1:0] SRC_JR  = 2'b10;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [1:0]            pc_src_q;
  logic                  if_valid_q;
  logic [DATA_WIDTH-1:0] if_instr_q;
  logic [DATA_WIDTH-1:0] if_pc_q;
  logic [31:0]           fetch_cnt_q;
  logic [DATA_WIDTH-1:0] pend_tgt_q;
  logic [1:0]            pend_src_q;

  logic                  redir;
  logic [DATA_WIDTH-1:0] redir_tgt;
  logic [1:0]            redir_src;

  // Redirect select: branch has priority, low two bits forced to zero.
  always_comb begin
    redir     = br_taken | jr_valid;
    redir_tgt = (br_taken ? br_target : jr_target) & ~DATA_WIDTH'(3);
    redir_src = br_taken ? SRC_BR : SRC_JR;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      pc_src_q    <= SRC_SEQ;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
      fetch_cnt_q <= '0;
      pend_tgt_q  <= '0;
      pend_src_q  <= SRC_SEQ;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_REQ;

        S_REQ: begin
          if (imem_ack) begin
            if (redir) begin
              // Data belongs to the wrong path; re-issue at the target.
              pc_q     <= redir_tgt;
              pc_src_q <= redir_src;
            end else begin
              if_instr_q <= imem_rdata;
              if_pc_q    <= pc_q;
              if_valid_q <= 1'b1;
              pc_q       <= pc_q + DATA_WIDTH'(4);
              pc_src_q   <= SRC_SEQ;
              state_q    <= S_HOLD;
            end
          end else if (redir) begin
            // Address must stay stable until ack, so park the target.
            pend_tgt_q <= redir_tgt;
            pend_src_q <= redir_src;
            state_q    <= S_DROP;
          end
        end

        S_DROP: begin
          if (imem_ack) begin
            pc_q     <= redir ? redir_tgt : pend_tgt_q;
            pc_src_q <= redir ? redir_src : pend_src_q;
            state_q  <= S_REQ;
          end else if (redir) begin
            pend_tgt_q <= redir_tgt;
            pend_src_q <= redir_src;
          end
        end

        S_HOLD: begin
          // A transfer coinciding with a redirect still counts; decode flushes it.
          if (id_ready) fetch_cnt_q <= fetch_cnt_q + 32'd1;
          if (redir) begin
            if_valid_q <= 1'b0;
            pc_q       <= redir_tgt;
            pc_src_q   <= redir_src;
            state_q    <= S_REQ;
          end else if (id_ready) begin
            if_valid_q <= 1'b0;
            state_q    <= S_REQ;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign pc        = pc_q;
  assign pc_src    = pc_src_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [31:0] pc;
  logic [1:0]  pc_src;
  logic [31:0] fetch_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_sequencer #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .jr_valid(jr_valid), .jr_target(jr_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready),
    .pc(pc), .pc_src(pc_src), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ack;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] bt;
    logic        jr;
    logic [31:0] jt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr, e_ipc;
    logic [1:0]  e_src;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic r, logic a, logic [31:0] rd, logic b, logic [31:0] btg,
                              logic j, logic [31:0] jtg, logic rdy,
                              logic ereq, logic [31:0] eaddr, logic evld, logic [31:0] einstr,
                              logic [31:0] eipc, logic [1:0] esrc, logic [31:0] ecnt);
    vec_t v;
    v.rst = r; v.ack = a; v.rdata = rd; v.br = b; v.bt = btg; v.jr = j; v.jt = jtg; v.rdy = rdy;
    v.e_req = ereq; v.e_addr = eaddr; v.e_vld = evld; v.e_instr = einstr; v.e_ipc = eipc;
    v.e_src = esrc; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_outputs(string tag, logic ereq, logic [31:0] eaddr, logic evld,
                               logic [31:0] einstr, logic [31:0] eipc, logic [1:0] esrc,
                               logic [31:0] ecnt);
    chk({tag, " imem_req"},  32'(imem_req),  32'(ereq));
    chk({tag, " imem_addr"}, imem_addr,      eaddr);
    chk({tag, " pc"},        pc,             eaddr);
    chk({tag, " if_valid"},  32'(if_valid),  32'(evld));
    chk({tag, " if_instr"},  if_instr,       einstr);
    chk({tag, " if_pc"},     if_pc,          eipc);
    chk({tag, " pc_src"},    32'(pc_src),    32'(esrc));
    chk({tag, " fetch_cnt"}, fetch_cnt,      ecnt);
  endtask

  task automatic drive(logic r, logic a, logic [31:0] rd, logic b, logic [31:0] btg,
                       logic j, logic [31:0] jtg, logic rdy);
    rst = r; imem_ack = a; imem_rdata = rd; br_taken = b; br_target = btg;
    jr_valid = j; jr_target = jtg; id_ready = rdy;
  endtask

  // Reference model: a fetch is outstanding unless we are in the post-reset
  // bubble or an instruction sits in the buffer. A redirect seen while the
  // fetch is unacknowledged is remembered and applied when the ack arrives.
  bit          m_bubble, m_buf, m_pend;
  logic [31:0] m_ptgt, m_pc, m_instr, m_ipc, m_cnt;
  logic [1:0]  m_psrc, m_src;

  task automatic model_step(logic r, logic a, logic [31:0] rd, logic b, logic [31:0] btg,
                            logic j, logic [31:0] jtg, logic rdy);
    logic [31:0] tgt;
    logic [1:0]  src;
    bit          redir;
    redir = b || j;
    tgt   = b ? {btg[31:2], 2'b00} : {jtg[31:2], 2'b00};
    src   = b ? 2'd1 : 2'd2;
    if (!r) begin
      m_bubble = 1; m_buf = 0; m_pend = 0; m_pc = 32'h0; m_src = 2'd0;
      m_instr = 32'h0; m_ipc = 32'h0; m_cnt = 32'h0;
    end else if (m_bubble) begin
      m_bubble = 0;
    end else if (m_buf) begin
      if (rdy) m_cnt = m_cnt + 1;
      if (redir) begin
        m_buf = 0; m_pc = tgt; m_src = src;
      end else if (rdy) begin
        m_buf = 0;
      end
    end else begin
      if (redir && a) begin
        m_pc = tgt; m_src = src; m_pend = 0;
      end else if (redir) begin
        m_pend = 1; m_ptgt = tgt; m_psrc = src;
      end else if (a && m_pend) begin
        m_pc = m_ptgt; m_src = m_psrc; m_pend = 0;
      end else if (a) begin
        m_instr = rd; m_ipc = m_pc; m_buf = 1; m_pc = m_pc + 32'd4; m_src = 2'd0;
      end
    end
  endtask

  initial begin
    //            rst ack rdata          br bt             jr jt            rdy | req addr           vld instr          ipc            src cnt
    tbl[0]  = mk(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        0,  0, 32'h0,         0, 32'h0,         32'h0,         0, 0);
    tbl[1]  = mk(1, 1, 32'h0000_0013,  0, 32'h0,         0, 32'h0,        1,  1, 32'h0,         0, 32'h0,         32'h0,         0, 0);
    tbl[2]  = mk(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        1,  0, 32'h4,         1, 32'h13,        32'h0,         0, 0);
    tbl[3]  = mk(1, 1, 32'hAA,         0, 32'h0,         0, 32'h0,        0,  1, 32'h4,         0, 32'h13,        32'h0,         0, 1);
    tbl[4]  = mk(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        0,  0, 32'h8,         1, 32'hAA,        32'h4,         0, 1);
    tbl[5]  = mk(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        0,  0, 32'h8,         1, 32'hAA,        32'h4,         0, 1);
    tbl[6]  = mk(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        0,  0, 32'h8,         1, 32'hAA,        32'h4,         0, 1);
    tbl[7]  = mk(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        1,  0, 32'h8,         1, 32'hAA,        32'h4,         0, 1);
    tbl[8]  = mk(1, 1, 32'hBB,         0, 32'h0,         0, 32'h0,        0,  1, 32'h8,         0, 32'hAA,        32'h4,         0, 2);
    tbl[9]  = mk(1, 0, 32'h0,          1, 32'h100,       0, 32'h0,        0,  0, 32'hC,         1, 32'hBB,        32'h8,         0, 2);
    tbl[10] = mk(1, 1, 32'hCC,         0, 32'h0,         0, 32'h0,        0,  1, 32'h100,       0, 32'hBB,        32'h8,         1, 2);
    tbl[11] = mk(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        1,  0, 32'h104,       1, 32'hCC,        32'h100,       0, 2);
    tbl[12] = mk(1, 0, 32'h0,          0, 32'h0,         1, 32'h203,      0,  1, 32'h104,       0, 32'hCC,        32'h100,       0, 3);
    tbl[13] = mk(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        0,  1, 32'h104,       0, 32'hCC,        32'h100,       0, 3);
    tbl[14] = mk(1, 1, 32'hDD,         0, 32'h0,         0, 32'h0,        0,  1, 32'h104,       0, 32'hCC,        32'h100,       0, 3);
    tbl[15] = mk(1, 0, 32'h0,          1, 32'h40,        1, 32'h80,       0,  1, 32'h200,       0, 32'hCC,        32'h100,       2, 3);
    tbl[16] = mk(1, 1, 32'h0,          0, 32'h0,         0, 32'h0,        0,  1, 32'h200,       0, 32'hCC,        32'h100,       2, 3);
    tbl[17] = mk(1, 1, 32'hEE,         0, 32'h0,         0, 32'h0,        0,  1, 32'h40,        0, 32'hCC,        32'h100,       1, 3);
    tbl[18] = mk(1, 0, 32'h0,          1, 32'h10,        0, 32'h0,        1,  0, 32'h44,        1, 32'hEE,        32'h40,        0, 3);
    tbl[19] = mk(1, 0, 32'h0,          0, 32'h0,         1, 32'h300,      0,  1, 32'h10,        0, 32'hEE,        32'h40,        1, 4);
    tbl[20] = mk(0, 1, 32'h0,          0, 32'h0,         0, 32'h0,        0,  1, 32'h10,        0, 32'hEE,        32'h40,        1, 4);
    tbl[21] = mk(1, 1, 32'hFF,         0, 32'h0,         0, 32'h0,        0,  0, 32'h0,         0, 32'h0,         32'h0,         0, 0);
    tbl[22] = mk(1, 1, 32'h99,         1, 32'h55,        0, 32'h0,        0,  1, 32'h0,         0, 32'h0,         32'h0,         0, 0);
    tbl[23] = mk(1, 1, 32'h0,          1, 32'hFFFF_FFFF, 0, 32'h0,        0,  1, 32'h54,        0, 32'h0,         32'h0,         1, 0);
    tbl[24] = mk(1, 1, 32'h77,         0, 32'h0,         0, 32'h0,        0,  1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         1, 0);
    tbl[25] = mk(1, 0, 32'h0,          0, 32'h0,         0, 32'h0,        0,  0, 32'h0,         1, 32'h77,        32'hFFFF_FFFC, 0, 0);

    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 26; i++) begin
      check_outputs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld,
                    tbl[i].e_instr, tbl[i].e_ipc, tbl[i].e_src, tbl[i].e_cnt);
      drive(tbl[i].rst, tbl[i].ack, tbl[i].rdata, tbl[i].br, tbl[i].bt,
            tbl[i].jr, tbl[i].jt, tbl[i].rdy);
      @(negedge clk);
    end

    // Randomized run against the reference model, starting from a reset cycle.
    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    model_step(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      logic r, a, b, j, rdy;
      logic [31:0] rd, btg, jtg;
      check_outputs($sformatf("rnd%0d", c), !m_bubble && !m_buf, m_pc, m_buf,
                    m_instr, m_ipc, m_src, m_cnt);
      r   = ($urandom_range(0, 99) != 0);
      a   = ($urandom_range(0, 1) == 1);
      b   = ($urandom_range(0, 7) == 0);
      j   = ($urandom_range(0, 6) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rd  = $urandom;
      btg = $urandom;
      jtg = $urandom;
      drive(r, a, rd, b, btg, j, jtg, rdy);
      model_step(r, a, rd, b, btg, j, jtg, rdy);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
